// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: CHANNELS strobes at clk*NUM/DEN with phase, pause and settle/ready.
// Optional half-period strobes cen_b are built when CLK_EN_GEN_PHASE_B_EN is defined.

module clk_en_gen_ch #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         go,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  input  logic [W-1:0] phase,
  output logic         cen,
`ifdef CLK_EN_GEN_PHASE_B_EN
  output logic         cen_b,
`endif
  output logic         cfg_err
);
  logic [W-1:0] n_q, d_q, p_q, acc, acc_nxt;
  logic [W:0]   s, d_ext;
  logic         wrap, run, bad;

  // s is one bit wider so n + acc never overflows before the compare
  assign d_ext   = {1'b0, d_q};
  assign s       = {1'b0, acc} + {1'b0, n_q};
  assign wrap    = (s >= d_ext);
  assign acc_nxt = wrap ? W'(s - d_ext) : W'(s);
  assign bad     = (d_q == '0) || (n_q > d_q) || (p_q >= d_q);
  assign run     = go & ~cfg_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_q     <= '0;
      d_q     <= W'(1);
      p_q     <= '0;
      acc     <= '0;
      cen     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bad;
      if (load) begin
        n_q <= num;
        d_q <= den;
        p_q <= phase;
        acc <= phase;
        cen <= 1'b0;
      end else if (run) begin
        acc <= acc_nxt;
        cen <= wrap;
      end else begin
        cen <= 1'b0;
      end
    end
  end

`ifdef CLK_EN_GEN_PHASE_B_EN
  logic [W-1:0] half;
  logic         hit_b;

  // crossing d/2 is judged on the pre-wrap sum; n==d always crosses
  assign half  = d_q >> 1;
  assign hit_b = (n_q == d_q) || ((acc < half) && (s >= {1'b0, half}));

  always_ff @(posedge clk) begin
    if (rst || load) cen_b <= 1'b0;
    else             cen_b <= run & hit_b;
  end
`endif
endmodule

module clk_en_gen #(
  parameter int CHANNELS = 4,
  parameter int W        = 16,
  parameter int SETTLE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CHANNELS*W-1:0] num,
  input  logic [CHANNELS*W-1:0] den,
  input  logic [CHANNELS*W-1:0] phase,
  input  logic                  load,
  input  logic                  pause,
  output logic [CHANNELS-1:0]   cen,
`ifdef CLK_EN_GEN_PHASE_B_EN
  output logic [CHANNELS-1:0]   cen_b,
`endif
  output logic                  ready,
  output logic [CHANNELS-1:0]   cfg_err
);
  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt;
  logic          go;

  // ready is registered from the count so it rises on the SETTLE-th edge
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt   <= CW'(SETTLE);
      ready <= 1'b0;
    end else begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      ready <= (cnt <= CW'(1));
    end
  end

  assign go = ready & ~pause;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    clk_en_gen_ch #(.W(W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .go      (go),
      .num     (num[i*W +: W]),
      .den     (den[i*W +: W]),
      .phase   (phase[i*W +: W]),
      .cen     (cen[i]),
`ifdef CLK_EN_GEN_PHASE_B_EN
      .cen_b   (cen_b[i]),
`endif
      .cfg_err (cfg_err[i])
    );
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen (CHANNELS=4, W=16, SETTLE=16).
// cen_b checks are compiled in only when CLK_EN_GEN_PHASE_B_EN is defined.

module tb_clk_en_gen;
  logic        clk = 1'b0;
  logic        rst, load, pause;
  logic [63:0] num, den, phase;
  logic [3:0]  cen, cfg_err;
  logic        ready;
`ifdef CLK_EN_GEN_PHASE_B_EN
  logic [3:0]  cen_b;
`endif

  int tests = 0;
  int fails = 0;

  clk_en_gen #(.CHANNELS(4), .W(16), .SETTLE(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .den     (den),
    .phase   (phase),
    .load    (load),
    .pause   (pause),
    .cen     (cen),
`ifdef CLK_EN_GEN_PHASE_B_EN
    .cen_b   (cen_b),
`endif
    .ready   (ready),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [15:0] n, input logic [15:0] d, input logic [15:0] p);
    num[c*16 +: 16]   = n;
    den[c*16 +: 16]   = d;
    phase[c*16 +: 16] = p;
  endtask

  logic [3:0] run_tab [9] = '{4'hC, 4'h8, 4'h8, 4'h9, 4'hE, 4'h8, 4'h8, 4'h9, 4'hE};
  logic [3:0] res_tab [8] = '{4'h8, 4'h8, 4'h9, 4'hC, 4'hA, 4'h8, 4'h9, 4'hC};
`ifdef CLK_EN_GEN_PHASE_B_EN
  logic [3:0] b_tab   [4] = '{4'h8, 4'hB, 4'hC, 4'h8};
`endif

  initial begin
    int         cnt [4];
    logic [3:0] seen;

    rst = 1'b1; load = 1'b0; pause = 1'b0;
    num = '0; den = '0; phase = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_cen", 32'(cen), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_cfg_err", 32'(cfg_err), 32'h0);

    // ch0 1/4, ch1 2/9, ch2 1/4 phase 3, ch3 7/7
    set_ch(0, 16'd1, 16'd4, 16'd0);
    set_ch(1, 16'd2, 16'd9, 16'd0);
    set_ch(2, 16'd1, 16'd4, 16'd3);
    set_ch(3, 16'd7, 16'd7, 16'd0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("load_cen", 32'(cen), 32'h0);
    chk("load_ready", 32'(ready), 32'h0);
    for (int k = 0; k < 15; k++) step();
    chk("settle_15", 32'(ready), 32'h0);
    step();
    chk("settle_16", 32'(ready), 32'h1);
    chk("settle_cen", 32'(cen), 32'h0);
    chk("cfg_ok", 32'(cfg_err), 32'h0);

    for (int e = 0; e < 9; e++) begin
      step();
      chk($sformatf("run_e%0d", e + 1), 32'(cen), 32'(run_tab[e]));
`ifdef CLK_EN_GEN_PHASE_B_EN
      if (e < 4) chk($sformatf("cenb_e%0d", e + 1), 32'(cen_b), 32'(b_tab[e]));
`endif
    end

    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < 9000; k++) begin
      step();
      for (int c = 0; c < 4; c++) if (cen[c]) cnt[c]++;
    end
    chk("rate_ch0", 32'(cnt[0]), 32'd2250);
    chk("rate_ch1", 32'(cnt[1]), 32'd2000);
    chk("rate_ch2", 32'(cnt[2]), 32'd2250);
    chk("rate_ch3", 32'(cnt[3]), 32'd9000);

    pause = 1'b1;
    seen  = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen |= cen;
    end
    chk("pause_quiet", 32'(seen), 32'h0);
    pause = 1'b0;
    for (int r = 0; r < 8; r++) begin
      step();
      chk($sformatf("resume_r%0d", r + 1), 32'(cen), 32'(res_tab[r]));
    end

    // load under pause: counter still settles, acc restarts at phase
    set_ch(0, 16'd1, 16'd4, 16'd2);
    load = 1'b1; pause = 1'b1;
    step();
    load = 1'b0;
    chk("lp_ready", 32'(ready), 32'h0);
    chk("lp_cen", 32'(cen), 32'h0);
    for (int k = 0; k < 15; k++) step();
    chk("lp_settle_15", 32'(ready), 32'h0);
    step();
    chk("lp_settle_16", 32'(ready), 32'h1);
    step(); step();
    chk("lp_paused_cen", 32'(cen), 32'h0);
    pause = 1'b0;
    step();
    chk("lp_r1", 32'(cen), 32'hC);
    step();
    chk("lp_r2", 32'(cen), 32'h9);

    // illegal: d=0, n>d, p>=d; ch3 stays n=d
    set_ch(0, 16'd0, 16'd0, 16'd0);
    set_ch(1, 16'd5, 16'd4, 16'd0);
    set_ch(2, 16'd1, 16'd4, 16'd4);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("err_lag", 32'(cfg_err), 32'h0);
    step();
    chk("err_set", 32'(cfg_err), 32'h7);
    for (int k = 0; k < 15; k++) step();
    chk("err_ready", 32'(ready), 32'h1);
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      for (int c = 0; c < 4; c++) if (cen[c]) cnt[c]++;
    end
    chk("err_silent", 32'(cnt[0] + cnt[1] + cnt[2]), 32'd0);
    chk("err_full_rate", 32'(cnt[3]), 32'd20);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_cen", 32'(cen), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h0);
    chk("mid_rst_err", 32'(cfg_err), 32'h0);
`ifdef CLK_EN_GEN_PHASE_B_EN
    chk("mid_rst_cenb", 32'(cen_b), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
